// File: rtl/scan_decoder_n.sv
// ---------------------------------------------------------------------------
// scan_decoder_n
//   Registered one-hot line decoder for the display/LED path. This is the
//   parametrised successor of the fixed 3x8 select decoder. It has two modes:
//     DIRECT : registers the one-hot decode of sel_i, with a latency of 1 clk.
//     SCAN   : walks a single active line across all N_OUT outputs. Each line
//              stays active for DWELL enabled cycles.
//
// Ports
//   clk_i    rising-edge clock
//   reset_i  asynchronous, active-high reset
//   en_i     advance enable. Low freezes all state. wrap_o still self-clears.
//   mode_i   0 = DIRECT, 1 = SCAN
//   sel_i    index decoded in DIRECT; start index on entry to SCAN
//   lines_o  registered one-hot (or all-zero) line vector
//   idx_o    index currently driven on lines_o
//   err_o    high while a DIRECT sel_i is out of range (lines_o all zero)
//   wrap_o   one-cycle pulse when SCAN moves from N_OUT-1 back to 0
// ---------------------------------------------------------------------------
module scan_decoder_n #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8,
  parameter int DWELL = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_OUT-1:0] lines_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             err_o,
  output logic             wrap_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_OUT-1:0] lines_q, lines_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [N_OUT-1:0] onehot_d;
  logic             sel_valid;

  // The extra leading bit keeps the compare correct when N_OUT == 2**SEL_W.
  assign sel_valid = ({1'b0, sel_i} < (SEL_W + 1)'(N_OUT));

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. When enabled, the mode input alone selects the state.
  // This also covers the first edge out of IDLE.
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = mode_i ? ST_SCAN : ST_DIRECT;
    end
  end

  // Output / datapath next-state logic.
  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    wrap_d  = 1'b0;   // A wrap pulse never lasts past one cycle, even when frozen.
    if (en_i) begin
      if (!mode_i) begin
        // DIRECT decode. This also runs on the edge that leaves SCAN or IDLE.
        dwell_d = '0;
        if (sel_valid) begin
          idx_d = sel_i;
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (state_q != ST_SCAN) begin
        // SCAN entry edge: seed from sel_i. An out-of-range sel_i starts at 0.
        idx_d   = sel_valid ? sel_i : '0;
        dwell_d = '0;
        err_d   = 1'b0;
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // One-hot decode of the next index.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_onehot
    assign onehot_d[gi] = (idx_d == SEL_W'(gi));
  end

  assign lines_d = ((state_d == ST_IDLE) || err_d) ? '0 : onehot_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lines_q <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      lines_q <= lines_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign lines_o = lines_q;
  assign idx_o   = idx_q;
  assign err_o   = err_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_decoder_n.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder_n
//   Drives two decoders from the same stimulus:
//     - the default configuration (N_OUT=8, DWELL=4)
//     - a sparse, fast configuration (N_OUT=6, DWELL=1)
//   Each decoder is compared against a behavioural model that follows the
//   mode/dwell rules using plain integers.
// ---------------------------------------------------------------------------
module tb_scan_decoder_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [7:0] lines_a;
  logic [2:0] idx_a;
  logic       err_a, wrap_a;
  logic [5:0] lines_b;
  logic [2:0] idx_b;
  logic       err_b, wrap_b;

  always #5 clk = ~clk;

  scan_decoder_n #(.SEL_W(3), .N_OUT(8), .DWELL(4)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .sel_i(sel),
    .lines_o(lines_a), .idx_o(idx_a), .err_o(err_a), .wrap_o(wrap_a)
  );

  scan_decoder_n #(.SEL_W(3), .N_OUT(6), .DWELL(1)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .en_i(en), .mode_i(mode), .sel_i(sel),
    .lines_o(lines_b), .idx_o(idx_b), .err_o(err_b), .wrap_o(wrap_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per configuration.
  // m_state: 0 = idle, 1 = direct, 2 = scan.
  int cfg_n[2] = '{8, 6};
  int cfg_d[2] = '{4, 1};
  int m_state[2], m_idx[2], m_cnt[2], m_err[2], m_wrap[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_lines(input int c);
    if (m_state[c] == 0) return 32'd0;
    if (m_state[c] == 1 && m_err[c] != 0) return 32'd0;
    return 32'd1 << m_idx[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_state[c] = 0; m_idx[c] = 0; m_cnt[c] = 0; m_err[c] = 0; m_wrap[c] = 0;
    end
  endtask

  // Apply one rising edge to both models.
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      bit valid;
      valid = (int'(sel) < cfg_n[c]);
      m_wrap[c] = 0;
      if (en) begin
        if (!mode) begin
          m_cnt[c] = 0;
          if (valid) begin
            m_idx[c] = int'(sel);
            m_err[c] = 0;
          end else begin
            m_err[c] = 1;
          end
          m_state[c] = 1;
        end else if (m_state[c] != 2) begin
          m_idx[c] = valid ? int'(sel) : 0;
          m_cnt[c] = 0;
          m_err[c] = 0;
          m_state[c] = 2;
        end else if (m_cnt[c] + 1 >= cfg_d[c]) begin
          m_cnt[c] = 0;
          m_idx[c] = (m_idx[c] + 1) % cfg_n[c];
          if (m_idx[c] == 0) m_wrap[c] = 1;
        end else begin
          m_cnt[c]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " A lines"}, 32'(lines_a), model_lines(0));
    check({tag, " A idx"},   32'(idx_a),   32'(m_idx[0]));
    check({tag, " A err"},   32'(err_a),   32'(m_err[0]));
    check({tag, " A wrap"},  32'(wrap_a),  32'(m_wrap[0]));
    check({tag, " B lines"}, 32'(lines_b), model_lines(1));
    check({tag, " B idx"},   32'(idx_b),   32'(m_idx[1]));
    check({tag, " B err"},   32'(err_b),   32'(m_err[1]));
    check({tag, " B wrap"},  32'(wrap_b),  32'(m_wrap[1]));
  endtask

  // Drive the inputs, take one clock edge, then check shortly afterwards.
  task automatic step(input string tag, input logic e, input logic m, input logic [2:0] s);
    en = e; mode = m; sel = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset asserted between clock edges. Outputs must clear at once.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all({tag, " rst-now"});
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all({tag, " rst-rel"});
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle with en low: everything stays at zero.
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 3'(i));

    // DIRECT sweep through every code. The upper codes are invalid for B.
    for (int i = 0; i < 8; i++) step("direct", 1'b1, 1'b0, 3'(i));
    step("direct3", 1'b1, 1'b0, 3'd3);
    step("direct7", 1'b1, 1'b0, 3'd7);

    // SCAN from 6. A dwells 4 cycles per line and wraps to 0.
    for (int i = 0; i < 12; i++) step("scan6", 1'b1, 1'b1, 3'd6);

    // Freeze mid-dwell for 3 cycles, then resume the count.
    step("scan-pre", 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) step("frozen", 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 6; i++) step("resume", 1'b1, 1'b1, 3'd0);

    // Freeze on the wrap cycle. wrap must still drop after one cycle.
    while (!(wrap_a === 1'b1) && n_chk < 4000) step("to-wrap", 1'b1, 1'b1, 3'd0);
    check("wrap reached", 32'(wrap_a), 32'd1);
    step("wrap-frozen", 1'b0, 1'b1, 3'd0);

    // Reset mid-scan, then SCAN->DIRECT switch at sel=2.
    step("scan-again", 1'b1, 1'b1, 3'd5);
    async_reset("midscan");
    step("rescan", 1'b1, 1'b1, 3'd1);
    step("rescan", 1'b1, 1'b1, 3'd1);
    step("to-direct2", 1'b1, 1'b0, 3'd2);
    check("direct2 lines", 32'(lines_a), 32'h04);

    // Mode toggled on consecutive edges.
    for (int i = 0; i < 8; i++) step("toggle", 1'b1, 1'(i % 2), 3'(7 - i));

    // Randomized phase.
    for (int i = 0; i < 800; i++) begin
      logic e, m;
      logic [2:0] s;
      e = ($urandom_range(0, 9) < 8);
      m = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      s = 3'($urandom_range(0, 7));
      step("rand", e, m, s);
      if ($urandom_range(0, 99) == 0) async_reset("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
